// File: rtl/tc_sram_rmw_pkg.sv
// Shared FSM encoding and default parameter values for the SRAM read-modify-write wrapper.
package tc_sram_rmw_pkg;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        IDLE     = 2'd1,
        RMW_WAIT = 2'd2,
        RMW_WR   = 2'd3
    } rmw_state_e;

    localparam int unsigned DefNumWords     = 32'd1024;
    localparam int unsigned DefDataWidth    = 32'd128;
    localparam int unsigned DefLatency      = 32'd1;
    localparam bit          DefClearOnReset = 1'b1;
    localparam int unsigned DefByteWidth    = 32'd8;

endpackage

// File: rtl/tc_sram.sv
// Behavioural SRAM with configurable read latency and byte enables. A word not written since
// reset reads back as the SimInit pattern ("ones" -> all ones, otherwise all zeros).
module tc_sram #(
    parameter int unsigned NumWords  = 32'd1024,
    parameter int unsigned DataWidth = 32'd128,
    parameter int unsigned ByteWidth = 32'd8,
    parameter int unsigned NumPorts  = 32'd1,
    parameter int unsigned Latency   = 32'd1,
    parameter string       SimInit   = "none",
    parameter int unsigned AddrWidth = (NumWords > 32'd1) ? $clog2(NumWords) : 32'd1,
    parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 32'd1) / ByteWidth
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NumPorts-1:0]                req_i,
    input  logic [NumPorts-1:0]                we_i,
    input  logic [NumPorts-1:0][AddrWidth-1:0] addr_i,
    input  logic [NumPorts-1:0][DataWidth-1:0] wdata_i,
    input  logic [NumPorts-1:0][BeWidth-1:0]   be_i,
    output logic [NumPorts-1:0][DataWidth-1:0] rdata_o
);

    localparam logic [DataWidth-1:0] InitWord =
        (SimInit == "ones") ? {DataWidth{1'b1}} : {DataWidth{1'b0}};

    logic [DataWidth-1:0]                         r_mem [NumWords];
    logic [NumWords-1:0]                          r_written;
    logic [DataWidth-1:0]                         r_rdata [NumPorts][Latency];
    logic [NumPorts-1:0]                          w_in_range;
    logic [NumPorts-1:0][DataWidth-1:0]           w_word;
    logic [NumPorts-1:0][DataWidth-1:0]           w_merged;
    logic [NumPorts-1:0][BeWidth*ByteWidth-1:0]   w_bit_mask;

    // Current word per port and the byte-enable merge of write data into it.
    always_comb begin
        w_in_range = '0;
        w_word     = '0;
        w_merged   = '0;
        w_bit_mask = '0;
        for (int p = 0; p < NumPorts; p++) begin
            w_in_range[p] = (32'(addr_i[p]) < NumWords);
            if (w_in_range[p] && r_written[addr_i[p]]) begin
                w_word[p] = r_mem[addr_i[p]];
            end else begin
                w_word[p] = InitWord;
            end
            for (int k = 0; k < BeWidth; k++) begin
                w_bit_mask[p][k*ByteWidth +: ByteWidth] = {ByteWidth{be_i[p][k]}};
            end
            w_merged[p] = (w_word[p] & ~w_bit_mask[p][DataWidth-1:0])
                        | (wdata_i[p] & w_bit_mask[p][DataWidth-1:0]);
        end
    end

    // Array write; out-of-range addresses are dropped.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NumPorts; p++) begin
            if (req_i[p] && we_i[p] && w_in_range[p]) begin
                r_mem[addr_i[p]] <= w_merged[p];
            end
        end
    end

    // Tracks which words hold written data rather than the initial image.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_written <= '0;
        end else begin
            for (int p = 0; p < NumPorts; p++) begin
                if (req_i[p] && we_i[p] && w_in_range[p]) begin
                    r_written[addr_i[p]] <= 1'b1;
                end
            end
        end
    end

    // Read-data pipeline, Latency stages deep.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int p = 0; p < NumPorts; p++) begin
                for (int s = 0; s < Latency; s++) begin
                    r_rdata[p][s] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < NumPorts; p++) begin
                if (req_i[p] && !we_i[p]) begin
                    r_rdata[p][0] <= w_word[p];
                end
                for (int s = 1; s < Latency; s++) begin
                    r_rdata[p][s] <= r_rdata[p][s-1];
                end
            end
        end
    end

    // Last pipeline stage drives the read port.
    always_comb begin
        rdata_o = '0;
        for (int p = 0; p < NumPorts; p++) begin
            rdata_o[p] = r_rdata[p][Latency-1];
        end
    end

endmodule

// File: rtl/tc_sram_rmw_wrapper.sv
// Single-port SRAM front end: zero-fills the array after reset and turns partial-mask writes
// into an internal read-modify-write, stalling requests while the merge is in flight.
module tc_sram_rmw_wrapper
    import tc_sram_rmw_pkg::*;
#(
    parameter int unsigned NumWords     = DefNumWords,
    parameter int unsigned DataWidth    = DefDataWidth,
    parameter int unsigned Latency      = DefLatency,
    parameter bit          ClearOnReset = DefClearOnReset,
    parameter string       SimInit      = "none",
    parameter int unsigned AddrWidth    = (NumWords > 32'd1) ? $clog2(NumWords) : 32'd1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    output logic                 gnt_o,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [DataWidth-1:0] bmask_i,
    output logic                 rvalid_o,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 init_done_o
);

    localparam int unsigned WaitWidth = $clog2(Latency + 32'd1);
    localparam int unsigned BeWidth   = (DataWidth + DefByteWidth - 32'd1) / DefByteWidth;

    rmw_state_e           r_state;
    rmw_state_e           w_state_next;
    logic [AddrWidth-1:0] r_init_cnt;
    logic [WaitWidth-1:0] r_wait_cnt;
    logic [Latency-1:0]   r_tag;
    logic                 r_gnt;
    logic                 r_init_done;
    logic [AddrWidth-1:0] r_rmw_addr;
    logic [DataWidth-1:0] r_rmw_wdata;
    logic [DataWidth-1:0] r_rmw_mask;
    logic                 w_accept;
    logic                 w_user_rd;
    logic                 w_rmw_start;
    logic                 w_sram_req;
    logic                 w_sram_we;
    logic [AddrWidth-1:0] w_sram_addr;
    logic [DataWidth-1:0] w_sram_wdata;
    logic [DataWidth-1:0] w_sram_rdata;

    // r_gnt is high exactly while the FSM sits in IDLE.
    assign w_accept    = req_i & r_gnt;
    assign w_user_rd   = w_accept & ~we_i;
    assign w_rmw_start = w_accept & we_i & ~(&bmask_i) & (|bmask_i);

    // Next-state and SRAM command decode.
    always_comb begin
        w_state_next = r_state;
        w_sram_req   = 1'b0;
        w_sram_we    = 1'b0;
        w_sram_addr  = addr_i;
        w_sram_wdata = wdata_i;
        case (r_state)
            INIT: begin
                if (ClearOnReset) begin
                    w_sram_req   = 1'b1;
                    w_sram_we    = 1'b1;
                    w_sram_addr  = r_init_cnt;
                    w_sram_wdata = '0;
                end else begin
                    w_sram_req = 1'b0;
                end
                if (!ClearOnReset || (r_init_cnt == AddrWidth'(NumWords - 32'd1))) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = INIT;
                end
            end
            IDLE: begin
                if (w_user_rd) begin
                    w_sram_req = 1'b1;
                end else if (w_accept && (&bmask_i)) begin
                    w_sram_req = 1'b1;
                    w_sram_we  = 1'b1;
                end else if (w_rmw_start) begin
                    w_sram_req   = 1'b1;
                    w_state_next = (Latency == 32'd1) ? RMW_WR : RMW_WAIT;
                end else begin
                    w_sram_req = 1'b0;
                end
            end
            RMW_WAIT: begin
                if (r_wait_cnt == WaitWidth'(Latency - 32'd1)) begin
                    w_state_next = RMW_WR;
                end else begin
                    w_state_next = RMW_WAIT;
                end
            end
            RMW_WR: begin
                w_sram_req   = 1'b1;
                w_sram_we    = 1'b1;
                w_sram_addr  = r_rmw_addr;
                w_sram_wdata = (w_sram_rdata & ~r_rmw_mask) | (r_rmw_wdata & r_rmw_mask);
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = INIT;
            end
        endcase
    end

    // FSM state, counters, grant/init flags and the user-read tag pipe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= INIT;
            r_gnt       <= 1'b0;
            r_init_done <= 1'b0;
            r_init_cnt  <= '0;
            r_wait_cnt  <= '0;
            r_tag       <= '0;
        end else begin
            r_state     <= w_state_next;
            r_gnt       <= (w_state_next == IDLE);
            r_init_done <= r_init_done | (w_state_next == IDLE);
            if (r_state == INIT) begin
                r_init_cnt <= r_init_cnt + AddrWidth'(1);
            end
            if (w_rmw_start) begin
                r_wait_cnt <= WaitWidth'(1);
            end else if (r_state == RMW_WAIT) begin
                r_wait_cnt <= r_wait_cnt + WaitWidth'(1);
            end
            r_tag[0] <= w_user_rd;
            for (int i = 1; i < Latency; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    // Holds the pending partial write until the old word returns.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rmw_addr  <= '0;
            r_rmw_wdata <= '0;
            r_rmw_mask  <= '0;
        end else if (w_rmw_start) begin
            r_rmw_addr  <= addr_i;
            r_rmw_wdata <= wdata_i;
            r_rmw_mask  <= bmask_i;
        end
    end

    assign gnt_o       = r_gnt;
    assign init_done_o = r_init_done;
    assign rvalid_o    = r_tag[Latency-1];
    assign rdata_o     = rvalid_o ? w_sram_rdata : '0;

    tc_sram #(
        .NumWords  (NumWords),
        .DataWidth (DataWidth),
        .ByteWidth (DefByteWidth),
        .NumPorts  (32'd1),
        .Latency   (Latency),
        .SimInit   (SimInit),
        .AddrWidth (AddrWidth)
    ) u_sram (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   (w_sram_req),
        .we_i    (w_sram_we),
        .addr_i  (w_sram_addr),
        .wdata_i (w_sram_wdata),
        .be_i    ({BeWidth{1'b1}}),
        .rdata_o (w_sram_rdata)
    );

endmodule

// File: doc/tc_sram_rmw_wrapper.md
TC_SRAM_RMW_WRAPPER -- requirements
Module: tc_sram_rmw_wrapper

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- NumWords, 1024, words in array.
- DataWidth, 128, word width.
- Latency, 1, SRAM read latency in cycles (>=1).
- ClearOnReset, 1'b1, zero-fill array after reset.
- SimInit, "none", passed to SRAM.
- AddrWidth: dependent, max(1, $clog2(NumWords)).
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk_i, in, 1, clock.
- rst_ni, in, 1, asynchronous active-low reset.
- req_i, in, 1, request.
- gnt_o, out, 1, request accepted this cycle when req_i&gnt_o.
- we_i, in, 1, write enable.
- addr_i, in, AddrWidth, word address.
- wdata_i, in, DataWidth, write data.
- bmask_i, in, DataWidth, per-bit write mask.
- rvalid_o, out, 1, read data valid.
- rdata_o, out, DataWidth, read data.
- init_done_o, out, 1, array initialised, accepting requests.
REQ-003 The block SHALL use one clock, clk_i; reset rst_ni SHALL be asynchronous and active-low.

Function
REQ-004 FSM states SHALL be INIT, IDLE, RMW_WAIT, RMW_WR; gnt_o=1 only in IDLE.
REQ-005 INIT: counter 0..NumWords-1 writes all-zero words, one per cycle; after last word -> IDLE, init_done_o=1 from cycle NumWords after reset release, held until next reset.
REQ-006 ClearOnReset=0: INIT SHALL last exactly one cycle with no SRAM writes.
REQ-007 Accepted read at cycle t: rvalid_o=1 with rdata_o=mem[addr] at cycle t+Latency; back-to-back reads SHALL be accepted every cycle.
REQ-008 rdata_o SHALL be driven 0 whenever rvalid_o=0.
REQ-009 Write with bmask_i all-ones: single SRAM write at cycle t, stays IDLE, no rvalid_o.
REQ-010 Write with bmask_i all-zero: accepted, no SRAM access, stays IDLE.
REQ-011 Partial-mask write at t: SRAM read at t, -> RMW_WAIT; wait counter reaches Latency -> RMW_WR at t+Latency writes (old & ~mask) | (wdata & mask); IDLE at t+Latency+1.
REQ-012 RMW internal read SHALL NOT raise rvalid_o; a per-stage tag shift register (Latency deep) SHALL distinguish user reads from RMW reads.
REQ-013 Reads accepted before an RMW SHALL complete in order with pre-RMW data; read of the same address accepted after RMW SHALL return merged data.
REQ-014 Write followed by read of the same address in the next cycle SHALL return the new data.
REQ-015 addr_i >= NumWords SHALL be accepted, with behaviour that of the underlying SRAM (undefined data); no hang.

Reset
REQ-016 On rst_ni low, at any time incl. mid-RMW or mid-INIT: gnt_o=0, rvalid_o=0, rdata_o=0, init_done_o=0, tag pipe cleared, state INIT, counter 0.
REQ-017 Pending in-flight reads at reset SHALL be dropped; INIT sweep SHALL restart from word 0.

Structure
REQ-018 Package tc_sram_rmw_pkg SHALL hold the state enum rmw_state_e and default parameter constants.
REQ-019 Storage SHALL be one instance of tc_sram (NumPorts=1, byte enables all-ones, ByteWidth=8); no other sub-module.

Verification (NumWords=16, DataWidth=8, Latency=2)
REQ-020 Reset release -> gnt_o=0 for 16 cycles, init_done_o=1 at cycle 16; reads of addr 0..15 all return 8'h00.
REQ-021 Full write 8'hA5 @3, then read @3 next cycle -> rvalid_o two cycles after accept, rdata_o=8'hA5.
REQ-022 mem[5]=8'hF0, masked write wdata=8'h0F, mask=8'h3C -> gnt_o low 2 cycles, subsequent read @5 = 8'hCC.
REQ-023 Reads @1,@2,@3 on consecutive cycles, then partial write @1 -> three rvalid_o pulses in order, no fourth pulse.
REQ-024 Assert rst_ni low during RMW_WAIT -> all outputs 0 immediately; after release, full 16-cycle sweep; mem[5]=8'h00.
REQ-025 ClearOnReset=0, SimInit="ones" -> init_done_o=1 one cycle after release, read @7 = 8'hFF.
